// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: states, opcodes, funcs, selects.
// Latency: none (constants and types only).
// Backpressure: none.
package mc_pkg;

  localparam logic [3:0] S_INIT     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_WB_ALU   = 4'd8;
  localparam logic [3:0] S_WB_MEM   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_ctr_e;

  // Result of decoding the IR fields that the EXEC states need.
  typedef struct packed {
    alu_ctr_e alu_ctr;
    logic     ext_op;
    logic     legal;
    logic     ovf_en;
  } dec_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the sequencer and the datapath: IR fields/flags in, enables/selects out.
// Latency: none (wiring only).
// Backpressure: MemRdy from the DataRAM stretches MEM_RD/MEM_WR.
interface multicycle_ctrl_if;
  logic [5:0] OP;
  logic [5:0] Func;
  logic       Z;
  logic       Overflow;
  logic       MemRdy;
  logic       PCWr;
  logic [1:0] PCSrc;
  logic       IRWr;
  logic       RegWr;
  logic       RegDst;
  logic       ALUSrc;
  logic       ExtOp;
  logic [2:0] ALUctr;
  logic       MemtoReg;
  logic       MemRd;
  logic       MemWr;
  logic       Illegal;
  logic       MemErr;
  logic [3:0] State;

  // Controller side.
  modport master (
    input  OP, Func, Z, Overflow, MemRdy,
    output PCWr, PCSrc, IRWr, RegWr, RegDst, ALUSrc, ExtOp, ALUctr,
           MemtoReg, MemRd, MemWr, Illegal, MemErr, State
  );

  // Datapath side.
  modport slave (
    output OP, Func, Z, Overflow, MemRdy,
    input  PCWr, PCSrc, IRWr, RegWr, RegDst, ALUSrc, ExtOp, ALUctr,
           MemtoReg, MemRd, MemWr, Illegal, MemErr, State
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decode.sv
// Combinational OP/Func decode into ALU operation, extender mode, overflow capture and legality.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output dec_t       dec
);

  // Unknown opcodes and unknown R-type funcs both come out with legal=0.
  always_comb begin
    dec = '{alu_ctr: ALU_ADD, ext_op: 1'b0, legal: 1'b0, ovf_en: 1'b0};
    case (op)
      OP_RTYPE: begin
        dec.legal = 1'b1;
        case (func)
          FN_ADD: begin dec.alu_ctr = ALU_ADD; dec.ovf_en = 1'b1; end
          FN_SUB: begin dec.alu_ctr = ALU_SUB; dec.ovf_en = 1'b1; end
          FN_AND: dec.alu_ctr = ALU_AND;
          FN_OR:  dec.alu_ctr = ALU_OR;
          FN_SLT: dec.alu_ctr = ALU_SLT;
          default: dec.legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        dec.legal  = 1'b1;
        dec.ext_op = 1'b1;
        dec.ovf_en = 1'b1;
      end
      OP_ORI: begin
        dec.legal   = 1'b1;
        dec.alu_ctr = ALU_OR;
      end
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: dec.legal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB FSM driving datapath enables and selects.
// Latency: R/I 4, lw 5+w, sw 4+w, branch/jump 3, illegal 2 cycles; outputs are combinational from state.
// Backpressure: MemRdy holds MEM_RD/MEM_WR; MULTICYCLE_MEM_TIMEOUT_EN aborts after MEM_TIMEOUT cycles.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input logic               Clk,
  input logic               Clrn,
  multicycle_ctrl_if.master bus
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       ovf_q;
  logic       mem_abort;
  dec_t       dec;

  mc_alu_decode u_dec (
    .op   (bus.OP),
    .func (bus.Func),
    .dec  (dec)
  );

  if (MEM_TIMEOUT < 2) begin : g_bad_timeout
    $error("multicycle_ctrl: MEM_TIMEOUT must be at least 2");
  end

`ifdef MULTICYCLE_MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  logic              in_mem;
  logic [WAIT_W-1:0] wait_q;

  assign in_mem = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  // Count unanswered MEM cycles; held at zero elsewhere so every access starts from zero.
  always_ff @(posedge Clk) begin
    if (!Clrn || !in_mem) wait_q <= '0;
    else if (!bus.MemRdy) wait_q <= wait_q + WAIT_W'(1);
  end

  // A late MemRdy in the final allowed cycle still wins over the abort.
  assign mem_abort = in_mem && !bus.MemRdy && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
`else
  assign mem_abort = 1'b0;
`endif

  // State register; reset wins from any state, including a pending memory access.
  always_ff @(posedge Clk) begin
    if (!Clrn) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  // Capture overflow in EXEC so WB_ALU can suppress the write; only add/sub/addi trap.
  always_ff @(posedge Clk) begin
    if (!Clrn) ovf_q <= 1'b0;
    else if (state_q == S_EXEC_R || state_q == S_EXEC_I) ovf_q <= bus.Overflow & dec.ovf_en;
  end

  // Next-state selection.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (dec.legal) begin
          case (bus.OP)
            OP_RTYPE:        state_d = S_EXEC_R;
            OP_ADDI, OP_ORI: state_d = S_EXEC_I;
            OP_LW, OP_SW:    state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE:  state_d = S_BRANCH;
            OP_J:            state_d = S_JUMP;
            default:         state_d = S_FETCH;
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (bus.OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (bus.MemRdy)     state_d = S_WB_MEM;
        else if (mem_abort) state_d = S_FETCH;
        else                state_d = S_MEM_RD;
      end
      S_MEM_WR: state_d = (bus.MemRdy || mem_abort) ? S_FETCH : S_MEM_WR;
      default:  state_d = S_FETCH;
    endcase
  end

  // Per-state enables and selects; anything not named for a state stays 0.
  always_comb begin
    bus.PCWr     = 1'b0;
    bus.PCSrc    = PC_SEQ;
    bus.IRWr     = 1'b0;
    bus.RegWr    = 1'b0;
    bus.RegDst   = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.ExtOp    = 1'b0;
    bus.ALUctr   = ALU_ADD;
    bus.MemtoReg = 1'b0;
    bus.MemRd    = 1'b0;
    bus.MemWr    = 1'b0;
    bus.Illegal  = 1'b0;
    bus.MemErr   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.IRWr = 1'b1;
        bus.PCWr = 1'b1;
      end
      S_DECODE: bus.Illegal = !dec.legal;
      S_EXEC_R: bus.ALUctr = dec.alu_ctr;
      S_EXEC_I: begin
        bus.ALUSrc = 1'b1;
        bus.ExtOp  = dec.ext_op;
        bus.ALUctr = dec.alu_ctr;
      end
      S_WB_ALU: begin
        bus.RegWr  = !ovf_q;
        bus.RegDst = (bus.OP == OP_RTYPE);
      end
      S_MEM_ADDR: begin
        bus.ALUSrc = 1'b1;
        bus.ExtOp  = 1'b1;
      end
      S_MEM_RD: begin
        bus.MemRd  = 1'b1;
        bus.MemErr = mem_abort;
      end
      S_MEM_WR: begin
        bus.MemWr  = 1'b1;
        bus.MemErr = mem_abort;
      end
      S_WB_MEM: begin
        bus.RegWr    = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUctr = ALU_SUB;
        bus.PCSrc  = PC_BRANCH;
        bus.PCWr   = (bus.OP == OP_BEQ) ? bus.Z : !bus.Z;
      end
      S_JUMP: begin
        bus.PCWr  = 1'b1;
        bus.PCSrc = PC_JUMP;
      end
      default: ;
    endcase
  end

  assign bus.State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected state/control words go through a scoreboard.
// Table of single instructions (MemRdy=1) plus hand sequences for wait states, reset and timeout.
// Built with MEM_TIMEOUT=4; timeout expectations follow MULTICYCLE_MEM_TIMEOUT_EN.
module tb_multicycle_ctrl;

  localparam logic [3:0] T_INIT = 4'd0, T_F = 4'd1, T_D = 4'd2, T_ER = 4'd3, T_EI = 4'd4,
                         T_MA = 4'd5, T_MR = 4'd6, T_MW = 4'd7, T_WBA = 4'd8, T_WBM = 4'd9,
                         T_BR = 4'd10, T_J = 4'd11;

  logic Clk = 1'b0;
  logic Clrn;
  always #5 Clk = ~Clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .Clk  (Clk),
    .Clrn (Clrn),
    .bus  (bus)
  );

  typedef struct {
    string      nm;
    logic [3:0] st;
    logic [15:0] cw;
  } exp_t;

  typedef struct {
    string       nm;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        ovf;
    int          n;
    logic [15:0] cd;
    logic [3:0]  s2, s3, s4;
    logic [15:0] c2, c3, c4;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [5:0] op_v = '0, fn_v = '0;
  logic       z_v = 1'b0, ovf_v = 1'b0, rdy_v = 1'b0, clrn_v = 1'b0;

  // {PCWr, PCSrc, IRWr, RegWr, RegDst, ALUSrc, ExtOp, ALUctr, MemtoReg, MemRd, MemWr, Illegal, MemErr}
  function automatic logic [15:0] mk(input logic pcwr, input logic [1:0] pcsrc, input logic irwr,
                                     input logic regwr, input logic regdst, input logic alusrc,
                                     input logic extop, input logic [2:0] alu, input logic m2r,
                                     input logic mrd, input logic mwr, input logic ill, input logic merr);
    return {pcwr, pcsrc, irwr, regwr, regdst, alusrc, extop, alu, m2r, mrd, mwr, ill, merr};
  endfunction

  function automatic logic [15:0] w_er(input logic [2:0] alu);
    return mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, alu, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [15:0] w_ei(input logic ext, input logic [2:0] alu);
    return mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, ext, alu, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [15:0] w_wb(input logic regwr, input logic regdst);
    return mk(1'b0, 2'b00, 1'b0, regwr, regdst, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [15:0] w_br(input logic pcwr);
    return mk(pcwr, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  logic [15:0] wF, wILL, wMA, wMR, wMRE, wMW, wMWE, wWBM, wJ;

  // Apply the current input set at the falling edge and queue what the DUT must show this cycle.
  task automatic cyc(input logic [3:0] st, input logic [15:0] cw, input string nm);
    exp_t e;
    @(negedge Clk);
    Clrn = clrn_v; bus.OP = op_v; bus.Func = fn_v; bus.Z = z_v;
    bus.Overflow = ovf_v; bus.MemRdy = rdy_v;
    e.nm = nm; e.st = st; e.cw = cw;
    sb.push_back(e);
  endtask

  task automatic add(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic ovf, input int n, input logic [15:0] cd,
                     input logic [3:0] s2, input logic [15:0] c2, input logic [3:0] s3,
                     input logic [15:0] c3, input logic [3:0] s4, input logic [15:0] c4);
    vec_t v;
    v.nm = nm; v.op = op; v.fn = fn; v.z = z; v.ovf = ovf; v.n = n; v.cd = cd;
    v.s2 = s2; v.c2 = c2; v.s3 = s3; v.c3 = c3; v.s4 = s4; v.c4 = c4;
    vt.push_back(v);
  endtask

  // Scoreboard consumer: one queued expectation per cycle, sampled 1 ns after the falling edge.
  initial begin
    exp_t e;
    logic [15:0] act;
    forever begin
      @(negedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = {bus.PCWr, bus.PCSrc, bus.IRWr, bus.RegWr, bus.RegDst, bus.ALUSrc, bus.ExtOp,
               bus.ALUctr, bus.MemtoReg, bus.MemRd, bus.MemWr, bus.Illegal, bus.MemErr};
        n_cmp++;
        if (bus.State !== e.st || act !== e.cw) begin
          n_bad++;
          $display("FAIL %s: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                   e.nm, bus.State, act, e.st, e.cw);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    Clrn = 1'b0; bus.OP = '0; bus.Func = '0; bus.Z = 1'b0; bus.Overflow = 1'b0; bus.MemRdy = 1'b0;

    wF   = mk(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wILL = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wMA  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wMR  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    wMRE = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    wMW  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wMWE = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wWBM = mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wJ   = mk(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    //  name       OP         Func       Z     Ovf   n  decode  s2     c2                   s3     c3                s4     c4
    add("add",   6'b000000, 6'b100000, 1'b0, 1'b0, 4, '0,   T_ER,  w_er(3'b000),        T_WBA, w_wb(1'b1, 1'b1), T_INIT, '0);
    add("subov", 6'b000000, 6'b100010, 1'b0, 1'b1, 4, '0,   T_ER,  w_er(3'b001),        T_WBA, w_wb(1'b0, 1'b1), T_INIT, '0);
    add("and",   6'b000000, 6'b100100, 1'b0, 1'b0, 4, '0,   T_ER,  w_er(3'b010),        T_WBA, w_wb(1'b1, 1'b1), T_INIT, '0);
    add("or",    6'b000000, 6'b100101, 1'b0, 1'b0, 4, '0,   T_ER,  w_er(3'b011),        T_WBA, w_wb(1'b1, 1'b1), T_INIT, '0);
    add("sltov", 6'b000000, 6'b101010, 1'b0, 1'b1, 4, '0,   T_ER,  w_er(3'b100),        T_WBA, w_wb(1'b1, 1'b1), T_INIT, '0);
    add("addi",  6'b001000, 6'b000000, 1'b0, 1'b0, 4, '0,   T_EI,  w_ei(1'b1, 3'b000),  T_WBA, w_wb(1'b1, 1'b0), T_INIT, '0);
    add("addiov",6'b001000, 6'b000000, 1'b0, 1'b1, 4, '0,   T_EI,  w_ei(1'b1, 3'b000),  T_WBA, w_wb(1'b0, 1'b0), T_INIT, '0);
    add("oriov", 6'b001101, 6'b000000, 1'b0, 1'b1, 4, '0,   T_EI,  w_ei(1'b0, 3'b011),  T_WBA, w_wb(1'b1, 1'b0), T_INIT, '0);
    add("lw",    6'b100011, 6'b000000, 1'b0, 1'b0, 5, '0,   T_MA,  wMA,                 T_MR,  wMR,              T_WBM, wWBM);
    add("sw",    6'b101011, 6'b000000, 1'b0, 1'b0, 4, '0,   T_MA,  wMA,                 T_MW,  wMW,              T_INIT, '0);
    add("beqZ1", 6'b000100, 6'b000000, 1'b1, 1'b0, 3, '0,   T_BR,  w_br(1'b1),          T_INIT, '0,              T_INIT, '0);
    add("beqZ0", 6'b000100, 6'b000000, 1'b0, 1'b0, 3, '0,   T_BR,  w_br(1'b0),          T_INIT, '0,              T_INIT, '0);
    add("bneZ0", 6'b000101, 6'b000000, 1'b0, 1'b0, 3, '0,   T_BR,  w_br(1'b1),          T_INIT, '0,              T_INIT, '0);
    add("bneZ1", 6'b000101, 6'b000000, 1'b1, 1'b0, 3, '0,   T_BR,  w_br(1'b0),          T_INIT, '0,              T_INIT, '0);
    add("j",     6'b000010, 6'b000000, 1'b0, 1'b0, 3, '0,   T_J,   wJ,                  T_INIT, '0,              T_INIT, '0);
    add("badop", 6'b111111, 6'b100000, 1'b0, 1'b0, 2, wILL, T_INIT, '0,                 T_INIT, '0,              T_INIT, '0);
    add("badfn", 6'b000000, 6'b000000, 1'b0, 1'b0, 2, wILL, T_INIT, '0,                 T_INIT, '0,              T_INIT, '0);

    // Reset: INIT with all outputs low while Clrn is held, and for the cycle it is released.
    @(negedge Clk);
    clrn_v = 1'b0;
    cyc(T_INIT, '0, "reset_hold");
    clrn_v = 1'b1;
    cyc(T_INIT, '0, "reset_release");

    // Table: one instruction at a time, MemRdy=1 throughout (also outside MEM states).
    foreach (vt[i]) begin
      op_v = vt[i].op; fn_v = vt[i].fn; z_v = vt[i].z; ovf_v = vt[i].ovf; rdy_v = 1'b1;
      cyc(T_F, wF, {vt[i].nm, "/fetch"});
      cyc(T_D, vt[i].cd, {vt[i].nm, "/decode"});
      if (vt[i].n > 2) cyc(vt[i].s2, vt[i].c2, {vt[i].nm, "/c2"});
      if (vt[i].n > 3) cyc(vt[i].s3, vt[i].c3, {vt[i].nm, "/c3"});
      if (vt[i].n > 4) cyc(vt[i].s4, vt[i].c4, {vt[i].nm, "/c4"});
    end

    // lw with three wait states: MemRd for four cycles, eight cycles FETCH to FETCH.
    op_v = 6'b100011; fn_v = '0; z_v = 1'b0; ovf_v = 1'b0; rdy_v = 1'b0;
    cyc(T_F, wF, "lw3w/fetch");
    cyc(T_D, '0, "lw3w/decode");
    cyc(T_MA, wMA, "lw3w/addr");
    for (int k = 0; k < 3; k++) cyc(T_MR, wMR, "lw3w/wait");
    rdy_v = 1'b1;
    cyc(T_MR, wMR, "lw3w/rdy");
    rdy_v = 1'b0;
    cyc(T_WBM, wWBM, "lw3w/wb");

    // sw with two wait states.
    op_v = 6'b101011;
    cyc(T_F, wF, "sw2w/fetch");
    cyc(T_D, '0, "sw2w/decode");
    cyc(T_MA, wMA, "sw2w/addr");
    cyc(T_MW, wMW, "sw2w/wait0");
    cyc(T_MW, wMW, "sw2w/wait1");
    rdy_v = 1'b1;
    cyc(T_MW, wMW, "sw2w/rdy");
    rdy_v = 1'b0;

    // Reset asserted while MEM_WR waits: INIT next cycle with MemWr low.
    cyc(T_F, wF, "swrst/fetch");
    cyc(T_D, '0, "swrst/decode");
    cyc(T_MA, wMA, "swrst/addr");
    cyc(T_MW, wMW, "swrst/wait");
    clrn_v = 1'b0;
    cyc(T_MW, wMW, "swrst/rst_sampled");
    cyc(T_INIT, '0, "swrst/init");
    clrn_v = 1'b1;
    cyc(T_INIT, '0, "swrst/release");

    // sw with MemRdy stuck low.
    cyc(T_F, wF, "swto/fetch");
    cyc(T_D, '0, "swto/decode");
    cyc(T_MA, wMA, "swto/addr");
    for (int k = 0; k < 3; k++) cyc(T_MW, wMW, "swto/wait");
`ifdef MULTICYCLE_MEM_TIMEOUT_EN
    cyc(T_MW, wMWE, "swto/abort");
`else
    for (int k = 0; k < 5; k++) cyc(T_MW, wMW, "swto/hold");
    clrn_v = 1'b0;
    cyc(T_MW, wMW, "swto/rst_sampled");
    cyc(T_INIT, '0, "swto/init");
    clrn_v = 1'b1;
    cyc(T_INIT, '0, "swto/release");
`endif

    // lw whose MemRdy arrives in the last allowed cycle: completes normally.
    op_v = 6'b100011;
    cyc(T_F, wF, "lwlate/fetch");
    cyc(T_D, '0, "lwlate/decode");
    cyc(T_MA, wMA, "lwlate/addr");
    for (int k = 0; k < 3; k++) cyc(T_MR, wMR, "lwlate/wait");
    rdy_v = 1'b1;
    cyc(T_MR, wMR, "lwlate/rdy");
    rdy_v = 1'b0;
    cyc(T_WBM, wWBM, "lwlate/wb");

`ifdef MULTICYCLE_MEM_TIMEOUT_EN
    // lw that times out: MemErr, no write-back, straight back to FETCH.
    cyc(T_F, wF, "lwto/fetch");
    cyc(T_D, '0, "lwto/decode");
    cyc(T_MA, wMA, "lwto/addr");
    for (int k = 0; k < 3; k++) cyc(T_MR, wMR, "lwto/wait");
    cyc(T_MR, wMRE, "lwto/abort");
`endif

    cyc(T_F, wF, "final/fetch");

    @(negedge Clk);
    #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
